// File: rtl/vliw_regfile.sv
// Shared integer register file for all VLIW IEU lanes: per-lane 2R/1W ports, program-order write merging,
// collision flag and saturating collision counter. Define VLIW_RF_BYPASS_EN for same-cycle write-to-read bypass.
module vliw_regfile #(
   parameter int NLANES  = 4,
   parameter int XLEN    = 64,
   parameter int NUMREGS = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NLANES*5-1:0]    a1_ieu,
   input  logic [NLANES*5-1:0]    a2_ieu,
   input  logic [NLANES*5-1:0]    a3_ieu,
   input  logic [NLANES-1:0]      we3_ieu,
   input  logic [NLANES*XLEN-1:0] wd3_ieu,
   output logic [NLANES*XLEN-1:0] rd1_ieu,
   output logic [NLANES*XLEN-1:0] rd2_ieu,
   output logic                   WriteCollisionW,
   output logic [15:0]            CollisionCount
);
   localparam int AW = (NUMREGS > 16) ? 5 : 4;

   logic [XLEN-1:0]   regs [1:NUMREGS-1];
   logic [NLANES-1:0] wr_ok;
   logic              collision;

   // x0 is hardwired zero; in E mode anything with bit 4 set does not exist.
   function automatic logic addr_ok(input logic [4:0] a);
      return (a != 5'd0) && ((NUMREGS > 16) || !a[4]);
   endfunction

   always_comb begin
      wr_ok = '0;
      for (int i = 0; i < NLANES; i++)
         wr_ok[i] = we3_ieu[i] && addr_ok(a3_ieu[5*i +: 5]);
   end

   always_comb begin
      collision = 1'b0;
      for (int i = 0; i < NLANES; i++)
         for (int j = i + 1; j < NLANES; j++)
            if (wr_ok[i] && wr_ok[j] && (a3_ieu[5*i +: 5] == a3_ieu[5*j +: 5]))
               collision = 1'b1;
   end

   // Ascending lane order: the youngest lane's assignment is the one that sticks.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int r = 1; r < NUMREGS; r++)
            regs[r] <= '0;
      end else begin
         for (int i = 0; i < NLANES; i++)
            if (wr_ok[i])
               regs[a3_ieu[5*i +: AW]] <= wd3_ieu[XLEN*i +: XLEN];
      end
   end

   always_comb begin
      logic [4:0]      ra;
      logic [XLEN-1:0] rv;
      rd1_ieu = '0;
      rd2_ieu = '0;
      ra      = '0;
      rv      = '0;
      for (int i = 0; i < NLANES; i++) begin
         for (int p = 0; p < 2; p++) begin
            ra = (p == 0) ? a1_ieu[5*i +: 5] : a2_ieu[5*i +: 5];
            rv = '0;
            if (reset && addr_ok(ra)) begin
               rv = regs[ra[AW-1:0]];
`ifdef VLIW_RF_BYPASS_EN
               for (int w = 0; w < NLANES; w++)
                  if (wr_ok[w] && (a3_ieu[5*w +: 5] == ra))
                     rv = wd3_ieu[XLEN*w +: XLEN];
`endif
            end
            if (p == 0)
               rd1_ieu[XLEN*i +: XLEN] = rv;
            else
               rd2_ieu[XLEN*i +: XLEN] = rv;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         WriteCollisionW <= 1'b0;
         CollisionCount  <= '0;
      end else begin
         WriteCollisionW <= collision;
         if (collision && (CollisionCount != 16'hFFFF))
            CollisionCount <= CollisionCount + 16'd1;
      end
   end
endmodule

// File: tb/tb_vliw_regfile.sv
// Bench for vliw_regfile: an I-base (32 regs) and an E-base (16 regs) instance share stimulus and
// are checked against array-based reference models; follows VLIW_RF_BYPASS_EN when defined.
`timescale 1ns/1ps
module tb_vliw_regfile;
   localparam int NL = 4;
   localparam int XL = 64;

   logic             clk = 1'b0;
   logic             reset;
   logic [NL*5-1:0]  a1, a2, a3;
   logic [NL-1:0]    we;
   logic [NL*XL-1:0] wd;
   logic [NL*XL-1:0] rd1_f, rd2_f, rd1_e, rd2_e;
   logic             coll_f, coll_e;
   logic [15:0]      cnt_f, cnt_e;

   always #5 clk = ~clk;

   vliw_regfile #(.NLANES(NL), .XLEN(XL), .NUMREGS(32)) dut_f (
      .clk(clk), .reset(reset), .a1_ieu(a1), .a2_ieu(a2), .a3_ieu(a3),
      .we3_ieu(we), .wd3_ieu(wd), .rd1_ieu(rd1_f), .rd2_ieu(rd2_f),
      .WriteCollisionW(coll_f), .CollisionCount(cnt_f));

   vliw_regfile #(.NLANES(NL), .XLEN(XL), .NUMREGS(16)) dut_e (
      .clk(clk), .reset(reset), .a1_ieu(a1), .a2_ieu(a2), .a3_ieu(a3),
      .we3_ieu(we), .wd3_ieu(wd), .rd1_ieu(rd1_e), .rd2_ieu(rd2_e),
      .WriteCollisionW(coll_e), .CollisionCount(cnt_e));

   logic [XL-1:0] m_f [32];
   logic [XL-1:0] m_e [32];
   logic          flag_f, flag_e;
   logic [15:0]   mc_f, mc_e;
   logic [XL-1:0] exp_q [$];
   int            n_cmp  = 0;
   int            n_fail = 0;

   task automatic check(input string tag, input logic [XL-1:0] got, input logic [XL-1:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic bit valid(input bit e, input logic [4:0] a);
      return (a != 5'd0) && !(e && a[4]);
   endfunction

   function automatic logic [XL-1:0] exp_read(input bit e, input logic [4:0] a);
      if (reset !== 1'b1 || !valid(e, a)) return '0;
`ifdef VLIW_RF_BYPASS_EN
      for (int i = NL - 1; i >= 0; i--)
         if (we[i] && a3[5*i +: 5] == a) return wd[XL*i +: XL];
`endif
      return e ? m_e[a] : m_f[a];
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         m_f[r] = '0;
         m_e[r] = '0;
      end
      flag_f = 1'b0; flag_e = 1'b0;
      mc_f = '0;     mc_e = '0;
   endtask

   task automatic set_lane(input int i, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [4:0] r3, input logic w, input logic [XL-1:0] d);
      a1[5*i +: 5] = r1;
      a2[5*i +: 5] = r2;
      a3[5*i +: 5] = r3;
      we[i] = w;
      wd[XL*i +: XL] = d;
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < NL; i++) begin
         exp_q.push_back(exp_read(1'b0, a1[5*i +: 5]));
         exp_q.push_back(exp_read(1'b0, a2[5*i +: 5]));
         exp_q.push_back(exp_read(1'b1, a1[5*i +: 5]));
         exp_q.push_back(exp_read(1'b1, a2[5*i +: 5]));
         check($sformatf("%s/l%0d/rd1_i", tag, i), rd1_f[XL*i +: XL], exp_q.pop_front());
         check($sformatf("%s/l%0d/rd2_i", tag, i), rd2_f[XL*i +: XL], exp_q.pop_front());
         check($sformatf("%s/l%0d/rd1_e", tag, i), rd1_e[XL*i +: XL], exp_q.pop_front());
         check($sformatf("%s/l%0d/rd2_e", tag, i), rd2_e[XL*i +: XL], exp_q.pop_front());
      end
      check({tag, "/flag_i"}, 64'(coll_f), 64'(flag_f));
      check({tag, "/flag_e"}, 64'(coll_e), 64'(flag_e));
      check({tag, "/cnt_i"},  64'(cnt_f),  64'(mc_f));
      check({tag, "/cnt_e"},  64'(cnt_e),  64'(mc_e));
   endtask

   // Count writers per address to decide collisions, then commit writes in program order.
   task automatic clock_edge();
      int          hf [32];
      int          he [32];
      bit          cf, ce;
      logic [4:0]  a;
      cf = 1'b0; ce = 1'b0;
      for (int r = 0; r < 32; r++) begin
         hf[r] = 0;
         he[r] = 0;
      end
      for (int i = 0; i < NL; i++) begin
         a = a3[5*i +: 5];
         if (we[i] && valid(1'b0, a)) hf[a]++;
         if (we[i] && valid(1'b1, a)) he[a]++;
      end
      for (int r = 0; r < 32; r++) begin
         if (hf[r] > 1) cf = 1'b1;
         if (he[r] > 1) ce = 1'b1;
      end
      @(posedge clk);
      if (reset === 1'b1) begin
         for (int i = 0; i < NL; i++) begin
            a = a3[5*i +: 5];
            if (we[i] && valid(1'b0, a)) m_f[a] = wd[XL*i +: XL];
            if (we[i] && valid(1'b1, a)) m_e[a] = wd[XL*i +: XL];
         end
         flag_f = cf;
         flag_e = ce;
         if (cf && mc_f != 16'hFFFF) mc_f++;
         if (ce && mc_e != 16'hFFFF) mc_e++;
      end
      #1;
   endtask

   task automatic cycle(input string tag);
      #3;
      check_all(tag);
      clock_edge();
   endtask

   initial begin
      logic [4:0] r1, r2, r3;
      reset = 1'b0;
      a1 = '0; a2 = '0; a3 = '0; we = '0; wd = '0;
      model_reset();
      #1;

      // Writes and reads while in reset must both be inert.
      for (int i = 0; i < NL; i++) set_lane(i, 5'(i + 1), 5'(i + 5), 5'(i + 1), 1'b1, 64'hAAAA + 64'(i));
      cycle("in_reset");

      reset = 1'b1;
      for (int i = 0; i < NL; i++) set_lane(i, 5'(i + 1), 5'(i + 5), 5'd0, 1'b0, '0);
      cycle("post_reset");

      set_lane(2, 5'd0, 5'd0, 5'd5, 1'b1, 64'hDEAD);
      set_lane(0, 5'd5, 5'd1, 5'd0, 1'b0, '0);
      cycle("wr_x5_same");
      we = '0;
      cycle("wr_x5_next");

      set_lane(0, 5'd7, 5'd5, 5'd7, 1'b1, 64'h11);
      set_lane(1, 5'd7, 5'd0, 5'd7, 1'b1, 64'h22);
      set_lane(2, 5'd7, 5'd7, 5'd0, 1'b0, '0);
      set_lane(3, 5'd5, 5'd7, 5'd7, 1'b1, 64'h33);
      cycle("coll_x7");
      we = '0;
      cycle("coll_x7_after");
      cycle("coll_x7_drop");

      set_lane(0, 5'd0, 5'd20, 5'd0, 1'b1, 64'h1234);
      set_lane(1, 5'd0, 5'd20, 5'd0, 1'b1, 64'hFFFF);
      set_lane(2, 5'd20, 5'd0, 5'd0, 1'b1, 64'h5678);
      set_lane(3, 5'd20, 5'd7, 5'd20, 1'b1, 64'h2020);
      cycle("x0_x20_same");
      we = '0;
      cycle("x0_x20_next");

      repeat (400) begin
         for (int i = 0; i < NL; i++) begin
            r1 = 5'($urandom_range(0, 7)); if ($urandom_range(0, 3) == 0) r1[4] = 1'b1;
            r2 = 5'($urandom_range(0, 7)); if ($urandom_range(0, 3) == 0) r2[4] = 1'b1;
            r3 = 5'($urandom_range(0, 7)); if ($urandom_range(0, 3) == 0) r3[4] = 1'b1;
            set_lane(i, r1, r2, r3, 1'($urandom_range(0, 1)), {$urandom(), $urandom()});
         end
         cycle("rand");
      end

      // Long run of back-to-back collisions to reach and hold counter saturation.
      for (int i = 0; i < NL; i++) set_lane(i, 5'd9, 5'd9, 5'd9, (i < 2) ? 1'b1 : 1'b0, '0);
      for (int k = 0; k < 65540; k++) begin
         wd[0 +: XL]  = {$urandom(), $urandom()};
         wd[XL +: XL] = {$urandom(), $urandom()};
         clock_edge();
         check("sat_flag_i", 64'(coll_f), 64'(flag_f));
         check("sat_flag_e", 64'(coll_e), 64'(flag_e));
      end
      check("sat_cnt_i", 64'(cnt_f), 64'hFFFF);
      check("sat_cnt_e", 64'(cnt_e), 64'hFFFF);
      we = '0;
      cycle("sat_tail");
      cycle("sat_drop");

      set_lane(0, 5'd3, 5'd9, 5'd3, 1'b1, 64'h42);
      set_lane(1, 5'd3, 5'd0, 5'd0, 1'b0, '0);
      cycle("wr_x3");
      we = '0;
      #2;
      check_all("x3_held");
      reset = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      clock_edge();
      reset = 1'b1;
      set_lane(0, 5'd3, 5'd9, 5'd3, 1'b1, 64'h55);
      cycle("post_rst_wr");
      we = '0;
      cycle("post_rst_rd");
      check("x3_final", rd1_f[XL +: XL], 64'h55);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
